z16_mem_arbiter: RTL and testbench

//  Shares the single-port Z16 data memory between two requesters: port 0 (CPU load/store)
//  and port 1 (debug/program loader). Round-robin arbitration, one access per cycle,

---
 rtl/z16_mem_arbiter.sv | 112 +++++++++++
 tb/tb_z16_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z16_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port Z16 data memory.
// Port 0 is the CPU load/store path and port 1 is the debug/program loader.
module z16_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_wen,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_stall,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_wen,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_stall,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e             r_last;
  port_e             w_last_nxt;
  logic              r_rsel;
  logic              r_rpend;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_rd0;
  logic              w_rd1;

  // On a tie the port that did not win last time goes next; reset blocks all grants.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_rst) begin
      if (i_m0_req && i_m1_req) begin
        if (r_last == PORT1) w_gnt0 = 1'b1;
        else                 w_gnt1 = 1'b1;
      end else if (i_m0_req) begin
        w_gnt0 = 1'b1;
      end else if (i_m1_req) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    w_last_nxt = r_last;
    if (w_gnt0)      w_last_nxt = PORT0;
    else if (w_gnt1) w_last_nxt = PORT1;
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wen   = 1'b0;
    if (w_gnt0) begin
      o_mem_addr  = i_m0_addr;
      o_mem_wdata = i_m0_wdata;
      o_mem_wen   = i_m0_wen;
    end else if (w_gnt1) begin
      o_mem_addr  = i_m1_addr;
      o_mem_wdata = i_m1_wdata;
      o_mem_wen   = i_m1_wen;
    end
  end

  assign w_rd0 = w_gnt0 & ~i_m0_wen;
  assign w_rd1 = w_gnt1 & ~i_m1_wen;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last     <= PORT1;
      r_rsel     <= 1'b0;
      r_rpend    <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_last  <= w_last_nxt;
      r_rpend <= w_rd0 | w_rd1;
      r_rsel  <= w_rd1;
      if (w_rd0) r_m0_rdata <= i_mem_rdata;
      if (w_rd1) r_m1_rdata <= i_mem_rdata;
    end
  end

  assign o_m0_gnt    = w_gnt0;
  assign o_m1_gnt    = w_gnt1;
  assign o_m0_stall  = i_m0_req & ~w_gnt0;
  assign o_m1_stall  = i_m1_req & ~w_gnt1;
  assign o_m0_rvalid = r_rpend & ~r_rsel;
  assign o_m1_rvalid = r_rpend & r_rsel;
  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Self-checking bench for z16_mem_arbiter: a port-level behavioural model checked every cycle,
// plus directed scenarios pinned with hand-computed literal values.
module tb_z16_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0Req, m0Wen, m1Req, m1Wen;
  logic [15:0] m0Addr, m0Wdata, m1Addr, m1Wdata;
  logic        m0Gnt, m0Stall, m0Rvalid, m1Gnt, m1Stall, m1Rvalid;
  logic [15:0] m0Rdata, m1Rdata;
  logic [15:0] memAddr, memWdata, memRdata;
  logic        memWen;

  int checks   = 0;
  int failures = 0;

  // External memory seen by the arbiter: combinational read, written on the clock edge.
  logic [15:0] mem [0:255];
  logic        memLoaded  = 1'b0;
  assign memRdata = mem[memAddr[7:0]];

  // Model state: who won last, and what each port should be showing on its read-return path.
  int          mLast      = 1;
  logic        modelReady = 1'b0;
  logic        expValid [0:1];
  logic [15:0] expData  [0:1];
  int          expG;

  z16_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0Req), .i_m0_wen(m0Wen), .i_m0_addr(m0Addr), .i_m0_wdata(m0Wdata),
    .o_m0_gnt(m0Gnt), .o_m0_stall(m0Stall), .o_m0_rvalid(m0Rvalid), .o_m0_rdata(m0Rdata),
    .i_m1_req(m1Req), .i_m1_wen(m1Wen), .i_m1_addr(m1Addr), .i_m1_wdata(m1Wdata),
    .o_m1_gnt(m1Gnt), .o_m1_stall(m1Stall), .o_m1_rvalid(m1Rvalid), .o_m1_rdata(m1Rdata),
    .o_mem_addr(memAddr), .o_mem_wen(memWen), .o_mem_wdata(memWdata), .i_mem_rdata(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which port should win right now: -1 none, else 0 or 1.
  function automatic int expGrant(input logic r, input logic q0, input logic q1, input int last);
    if (r) return -1;
    if (q0 && q1) return (last == 0) ? 1 : 0;
    if (q0) return 0;
    if (q1) return 1;
    return -1;
  endfunction

  always_comb expG = expGrant(rst, m0Req, m1Req, mLast);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on the same edge the DUT updates; memory write comes from the DUT's own outputs.
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10] <= 16'hBEEF;
      mem[8'h02] <= 16'h2222;
      mem[8'h04] <= 16'h4444;
      memLoaded  <= 1'b1;
    end
    if (rst) begin
      mLast       <= 1;
      expValid[0] <= 1'b0;
      expValid[1] <= 1'b0;
      expData[0]  <= 16'h0000;
      expData[1]  <= 16'h0000;
      modelReady  <= 1'b1;
    end else begin
      expValid[0] <= (expG == 0) && !m0Wen;
      expValid[1] <= (expG == 1) && !m1Wen;
      if (expG == 0 && !m0Wen) expData[0] <= mem[m0Addr[7:0]];
      if (expG == 1 && !m1Wen) expData[1] <= mem[m1Addr[7:0]];
      if (expG >= 0) mLast <= expG;
    end
    if (memLoaded && memWen) mem[memAddr[7:0]] <= memWdata;
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (modelReady) begin
      logic [15:0] eAddr, eWdata;
      logic        eWen;
      eAddr  = 16'h0000;
      eWdata = 16'h0000;
      eWen   = 1'b0;
      if (expG == 0) begin eAddr = m0Addr; eWdata = m0Wdata; eWen = m0Wen; end
      if (expG == 1) begin eAddr = m1Addr; eWdata = m1Wdata; eWen = m1Wen; end
      checkOutput("m0_gnt",    m0Gnt,    expG == 0);
      checkOutput("m1_gnt",    m1Gnt,    expG == 1);
      checkOutput("m0_stall",  m0Stall,  m0Req && expG != 0);
      checkOutput("m1_stall",  m1Stall,  m1Req && expG != 1);
      checkOutput("mem_addr",  memAddr,  eAddr);
      checkOutput("mem_wen",   memWen,   eWen);
      checkOutput("mem_wdata", memWdata, eWdata);
      checkOutput("m0_rvalid", m0Rvalid, expValid[0]);
      checkOutput("m1_rvalid", m1Rvalid, expValid[1]);
      checkOutput("m0_rdata",  m0Rdata,  expData[0]);
      checkOutput("m1_rdata",  m1Rdata,  expData[1]);
    end
  end

  task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                               input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
    m0Req = r0; m0Wen = w0; m0Addr = a0; m0Wdata = d0;
    m1Req = r1; m1Wen = w1; m1Addr = a1; m1Wdata = d1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic toCheckPoint();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    toCheckPoint();
    checkOutput("rst_gnt0", m0Gnt, 0);
    checkOutput("rst_rvalid0", m0Rvalid, 0);
    checkOutput("rst_rdata1", m1Rdata, 16'h0000);
    step();

    // Lone port 0 read
    rst = 1'b0;
    applyStimulus(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    toCheckPoint();
    checkOutput("t1_gnt0", m0Gnt, 1);
    checkOutput("t1_addr", memAddr, 16'h0010);
    step();
    idle();
    toCheckPoint();
    checkOutput("t1_rvalid0", m0Rvalid, 1);
    checkOutput("t1_rdata0", m0Rdata, 16'hBEEF);
    checkOutput("t1_rvalid1", m1Rvalid, 0);
    step();

    // Port 1 write then port 0 reads it back
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 1, 16'h0020, 16'h1234);
    toCheckPoint();
    checkOutput("t2_gnt1", m1Gnt, 1);
    checkOutput("t2_wen", memWen, 1);
    checkOutput("t2_addr", memAddr, 16'h0020);
    step();
    toCheckPoint();
    checkOutput("t2_wr_no_rvalid1", m1Rvalid, 0);
    step();
    applyStimulus(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0);
    step();
    idle();
    toCheckPoint();
    checkOutput("t2_rdata0", m0Rdata, 16'h1234);
    checkOutput("t2_rvalid1", m1Rvalid, 0);
    step();

    // Idle keeps the last winner (port 0), so a tie afterwards goes to port 1
    repeat (3) begin
      toCheckPoint();
      checkOutput("t6_idle_gnt", {m0Gnt, m1Gnt}, 2'b00);
      checkOutput("t6_idle_addr", memAddr, 16'h0000);
      checkOutput("t6_idle_wen", memWen, 0);
      step();
    end
    applyStimulus(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0002, 16'h0);
    toCheckPoint();
    checkOutput("t6_tie_gnt1", m1Gnt, 1);
    checkOutput("t6_tie_stall0", m0Stall, 1);
    step();
    applyStimulus(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    toCheckPoint();
    checkOutput("t6_hold_gnt0", m0Gnt, 1);
    step();
    idle();
    step();

    // Both requesting continuously from reset: 0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(1, 0, 16'h0002, 16'h0, 1, 0, 16'h0004, 16'h0);
    toCheckPoint();
    checkOutput("t3_c0_gnt", {m0Gnt, m1Gnt}, 2'b10);
    checkOutput("t3_c0_stall1", m1Stall, 1);
    step();
    toCheckPoint();
    checkOutput("t3_c1_gnt", {m0Gnt, m1Gnt}, 2'b01);
    checkOutput("t3_c1_stall0", m0Stall, 1);
    checkOutput("t3_c1_rv", {m0Rvalid, m1Rvalid}, 2'b10);
    checkOutput("t3_c1_rdata0", m0Rdata, 16'h2222);
    step();
    toCheckPoint();
    checkOutput("t3_c2_gnt", {m0Gnt, m1Gnt}, 2'b10);
    checkOutput("t3_c2_rv", {m0Rvalid, m1Rvalid}, 2'b01);
    checkOutput("t3_c2_rdata1", m1Rdata, 16'h4444);
    step();
    toCheckPoint();
    checkOutput("t3_c3_gnt", {m0Gnt, m1Gnt}, 2'b01);
    checkOutput("t3_c3_stall0", m0Stall, 1);
    step();
    idle();
    step();

    // Reset right after a granted read; write during reset must be dropped
    applyStimulus(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    step();
    rst = 1'b1;
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 1, 16'h0030, 16'h5555);
    toCheckPoint();
    checkOutput("t5_rst_wen", memWen, 0);
    checkOutput("t5_rst_gnt1", m1Gnt, 0);
    step();
    rst = 1'b0;
    idle();
    toCheckPoint();
    checkOutput("t5_rvalid0", m0Rvalid, 0);
    checkOutput("t5_rdata0", m0Rdata, 16'h0000);
    checkOutput("t5_rdata1", m1Rdata, 16'h0000);
    checkOutput("t5_mem30", mem[8'h30], 16'h0000);
    step();

    // Mixed traffic, checked by the model each cycle
    applyStimulus(1, 1, 16'h0040, 16'hAAAA, 0, 0, 16'h0, 16'h0);
    step();
    applyStimulus(1, 0, 16'h0040, 16'h0, 1, 1, 16'h0041, 16'hBBBB);
    step();
    applyStimulus(1, 0, 16'h0040, 16'h0, 1, 0, 16'h0041, 16'h0);
    step();
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 0, 16'h0041, 16'h0);
    toCheckPoint();
    checkOutput("mix_rdata0", m0Rdata, 16'hAAAA);
    step();
    idle();
    toCheckPoint();
    checkOutput("mix_rdata1", m1Rdata, 16'hBBBB);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
